// File: rtl/cpu_pkg.sv
// Shared core types and widths.
// Used by the fetch-side instruction cache.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 16;
   localparam int LINE_W  = 64;
   localparam int OFF_W   = 2;

   typedef enum logic {
      IDLE,
      WAIT
   } icache_state_t;

   function automatic logic [INSTR_W-1:0] line_word(
      input logic [LINE_W-1:0] line,
      input logic [OFF_W-1:0]  off
   );
      return line[{off, 4'h0} +: INSTR_W];
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped I-cache.
// Flop based, combinational read, one write port.
module icache_line_store
   import cpu_pkg::*;
#(
   parameter int LINES = 8,
   parameter int TAG_W = 11,
   localparam int IB   = $clog2(LINES)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [IB-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              wr_en,
   input  logic [IB-1:0]     wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              wr_valid,
   input  logic              clear_all
);

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_line  = data_q[rd_idx];

   // Valid bits: the fill write wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (clear_all)
            valid_q <= '0;
         if (wr_en)
            valid_q[wr_idx] <= wr_valid;
      end
   end

   // Tag and data payload, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with line refill,
// whole-cache flush and a saturating miss counter.
module icache_direct
   import cpu_pkg::*;
#(
   parameter int LINES = 8,
   parameter int WORDS = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              flush,
   output logic [INSTR_W-1:0] instr,
   output logic              hit,
   output logic              stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rdy,
   input  logic [LINE_W-1:0] mem_data,
   output logic [15:0]       miss_cnt
);

   localparam int OFF_B = $clog2(WORDS);
   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF_B - IB;
   localparam int LA_W  = ADDR_W - OFF_B;

   icache_state_t state_q, state_d;

   logic [LA_W-1:0]   miss_line_q;
   logic              drop_q;
   logic [15:0]       miss_cnt_q;

   logic [IB-1:0]     cur_idx;
   logic [TAG_W-1:0]  cur_tag;
   logic [IB-1:0]     fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_line;
   logic              miss;
   logic              fill;

   assign cur_idx  = addr[OFF_B +: IB];
   assign cur_tag  = addr[ADDR_W-1 -: TAG_W];
   assign fill_idx = miss_line_q[IB-1:0];
   assign fill_tag = miss_line_q[LA_W-1 -: TAG_W];

   icache_line_store #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (cur_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_en     (fill),
      .wr_idx    (fill_idx),
      .wr_tag    (fill_tag),
      .wr_data   (mem_data),
      .wr_valid  (!drop_q && !flush),
      .clear_all (flush && !rst)
   );

   // Lookup, stall and next-state; all quiet while in reset.
   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      stall   = 1'b0;
      miss    = 1'b0;
      fill    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (rd_en) begin
                  if (rd_valid && rd_tag == cur_tag) begin
                     hit = 1'b1;
                  end else begin
                     stall   = 1'b1;
                     miss    = 1'b1;
                     state_d = WAIT;
                  end
               end
            end
            WAIT: begin
               stall = 1'b1;
               if (mem_rdy) begin
                  fill    = 1'b1;
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   assign instr    = hit ? line_word(rd_line, addr[OFF_B-1:0]) : '0;
   assign mem_req  = !rst && state_q == WAIT;
   assign mem_addr = {miss_line_q, {OFF_B{1'b0}}};
   assign miss_cnt = miss_cnt_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Capture the line address of the access that missed.
   always_ff @(posedge clk) begin
      if (rst)
         miss_line_q <= '0;
      else if (miss)
         miss_line_q <= addr[ADDR_W-1:OFF_B];
   end

   // A flush while a refill is in flight marks that line stale.
   always_ff @(posedge clk) begin
      if (rst)
         drop_q <= 1'b0;
      else if (fill)
         drop_q <= 1'b0;
      else if (state_q == WAIT && flush)
         drop_q <= 1'b1;
   end

   // Saturating miss counter.
   always_ff @(posedge clk) begin
      if (rst)
         miss_cnt_q <= '0;
      else if (miss && miss_cnt_q != 16'hFFFF)
         miss_cnt_q <= miss_cnt_q + 16'd1;
   end

endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against a
// line-address reference model plus directed scenarios.
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic [15:0] addr;
   logic        flush;
   logic [15:0] instr;
   logic        hit;
   logic        stall;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rdy;
   logic [63:0] mem_data;
   logic [15:0] miss_cnt;

   icache_direct #(
      .LINES (8),
      .WORDS (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .addr     (addr),
      .flush    (flush),
      .instr    (instr),
      .hit      (hit),
      .stall    (stall),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_rdy  (mem_rdy),
      .mem_data (mem_data),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   bit          m_valid [8];
   logic [13:0] m_line  [8];
   bit          m_wait;
   bit          m_drop;
   logic [15:0] m_miss;
   logic [15:0] m_cnt;
   int          m_lat;
   int          fixed_lat = -1;
   bit          idle_rdy  = 1'b0;

   logic        o_hit;
   logic        o_stall;
   logic        o_req;
   logic [15:0] o_instr;
   logic [15:0] o_maddr;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] line_of(input logic [15:0] a);
      logic [15:0] la;
      logic [63:0] r;
      la = {a[15:2], 2'b00};
      if (la == 16'h0010)
         return 64'h4444_3333_2222_1111;
      for (int k = 0; k < 4; k++)
         r[k*16 +: 16] = (la ^ 16'hA5C3) + 16'(k * 257);
      return r;
   endfunction

   function automatic logic [15:0] word_of(input logic [15:0] a);
      logic [63:0] l;
      l = line_of(a);
      return l[{a[1:0], 4'h0} +: 16];
   endfunction

   task automatic step(input logic rd,
                       input logic [15:0] a,
                       input logic fl);
      logic [2:0]  i;
      logic [2:0]  mi;
      logic        eh;
      logic        es;
      logic        rdy;
      @(negedge clk);
      rst   = 1'b0;
      rd_en = rd;
      addr  = a;
      flush = fl;
      if (m_wait) begin
         rdy      = (m_lat == 0);
         mem_data = rdy ? line_of(m_miss) : {$urandom, $urandom};
      end else begin
         rdy      = idle_rdy || ($urandom_range(0, 3) == 0);
         mem_data = {$urandom, $urandom};
      end
      mem_rdy = rdy;
      #1;
      i  = a[4:2];
      eh = !m_wait && rd && m_valid[i] && m_line[i] == a[15:2];
      es = m_wait || (rd && !eh);
      check("hit", hit, eh);
      check("stall", stall, es);
      check("instr", instr, eh ? word_of(a) : 16'h0);
      check("mem_req", mem_req, m_wait);
      if (m_wait)
         check("mem_addr", mem_addr, {m_miss[15:2], 2'b00});
      check("miss_cnt", miss_cnt, m_cnt);
      o_hit   = hit;
      o_stall = stall;
      o_req   = mem_req;
      o_instr = instr;
      o_maddr = mem_addr;
      if (fl)
         foreach (m_valid[k]) m_valid[k] = 1'b0;
      if (m_wait) begin
         if (rdy) begin
            mi          = m_miss[4:2];
            m_valid[mi] = !(m_drop || fl);
            m_line[mi]  = m_miss[15:2];
            m_drop      = 1'b0;
            m_wait      = 1'b0;
         end else begin
            if (fl)
               m_drop = 1'b1;
            m_lat--;
         end
      end else if (rd && !eh) begin
         m_wait = 1'b1;
         m_miss = a;
         m_lat  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
         if (m_cnt != 16'hFFFF)
            m_cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rd_en    = 1'b1;
      addr     = 16'($urandom);
      flush    = 1'b0;
      mem_rdy  = 1'b1;
      mem_data = {$urandom, $urandom};
      #1;
      check("rst_hit", hit, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_instr", instr, 16'h0);
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_wait = 1'b0;
      m_drop = 1'b0;
      m_cnt  = 16'h0;
   endtask

   task automatic access(input logic [15:0] a, output int stalls);
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, a, 1'b0);
         if (!o_stall)
            return;
         stalls++;
      end
      check("access_timeout", o_stall, 1'b0);
   endtask

   initial begin
      int nst;
      int s;
      logic [15:0] ra;
      logic [15:0] req_addr;

      rst      = 1'b1;
      rd_en    = 1'b0;
      addr     = 16'h0;
      flush    = 1'b0;
      mem_rdy  = 1'b0;
      mem_data = 64'h0;
      do_reset();

      // cold miss, memory answers in WAIT cycle 3
      fixed_lat = 2;
      nst = 0;
      req_addr = 16'hFFFF;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 16'h0012, 1'b0);
         if (o_req)
            req_addr = o_maddr;
         if (!o_stall)
            break;
         nst++;
      end
      check("cold_mem_addr", req_addr, 16'h0010);
      check("cold_stall_cycles", nst, 4);
      check("cold_hit", o_hit, 1'b1);
      check("cold_instr", o_instr, 16'h3333);
      check("cold_cnt", miss_cnt, 16'd1);

      // same-line hits
      step(1'b1, 16'h0010, 1'b0);
      check("hit_w0", o_instr, 16'h1111);
      step(1'b1, 16'h0011, 1'b0);
      check("hit_w1", o_instr, 16'h2222);
      step(1'b1, 16'h0013, 1'b0);
      check("hit_w3", o_instr, 16'h4444);
      check("hit_w3_flag", o_hit, 1'b1);
      check("hits_cnt", miss_cnt, 16'd1);

      // conflict eviction
      do_reset();
      fixed_lat = 0;
      access(16'h0012, s);
      check("conf_miss_a", s > 0, 1'b1);
      access(16'h0032, s);
      check("conf_miss_b", s > 0, 1'b1);
      access(16'h0012, s);
      check("conf_miss_a2", s > 0, 1'b1);
      check("conf_cnt", miss_cnt, 16'd3);

      // flush between miss and fill
      fixed_lat = 1;
      step(1'b1, 16'h0050, 1'b0);
      step(1'b1, 16'h0050, 1'b1);
      step(1'b1, 16'h0050, 1'b0);
      step(1'b1, 16'h0050, 1'b0);
      check("flush_retry_miss", o_stall, 1'b1);
      step(1'b1, 16'h0050, 1'b0);
      check("flush_rereq", o_req, 1'b1);
      check("flush_readdr", o_maddr, 16'h0050);
      access(16'h0050, s);
      check("flush_refill_hit", o_hit, 1'b1);

      // reset while a request is outstanding
      fixed_lat = 3;
      step(1'b1, 16'h0070, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      check("midwait_req", o_req, 1'b1);
      do_reset();
      idle_rdy = 1'b1;
      step(1'b0, 16'h0000, 1'b0);
      idle_rdy = 1'b0;
      check("post_rst_req", o_req, 1'b0);
      check("post_rst_cnt", miss_cnt, 16'd0);
      step(1'b1, 16'h0070, 1'b0);
      check("post_rst_miss", o_stall, 1'b1);
      access(16'h0070, s);

      // randomized traffic
      fixed_lat = -1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            ra = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
               ra[15:12] = 4'($urandom);
            step($urandom_range(0, 9) < 8, ra,
                 $urandom_range(0, 32) == 0);
         end
      end

      // saturation: preload near the top, then keep missing
      do_reset();
      step(1'b0, 16'h0000, 1'b0);
      dut.miss_cnt_q = 16'hFFFD;
      m_cnt = 16'hFFFD;
      fixed_lat = 0;
      access(16'h0012, s);
      access(16'h0032, s);
      check("sat_reach", miss_cnt, 16'hFFFF);
      access(16'h0012, s);
      access(16'h0032, s);
      check("sat_hold", miss_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
